direct_mapped_cache: RTL and testbench
======================================

# direct_mapped_cache

Parametrised direct-mapped cache controller with tag/valid/data storage, hit/miss detection, multi-word block refill and write-through. It sits between the CPU word port and the main-memory port. It splits the CPU word address into tag, index and word offset with the same field layout as the cache address decoder: tag in the MSBs, then index, then word offset in the LSBs. It also keeps saturating hit/miss statistics.

## Interface
- addrSize, 30: width of the word address.
- offset, 2: word-offset bits. A block holds 2^offset words.
- index, 6: index bits. The cache holds 2^index lines.
- dataWidth, 32: width of one data word.
- cntWidth, 16: width of each statistics counter.
- tag width is derived as addrSize-offset-index and must be at least 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpuReq  in  1  request strobe; sampled only in IDLE.
- cpuWe  in  1  1 = write, 0 = read.
- cpuAddr  in  addrSize  word address.
- cpuWData  in  dataWidth  write data.
- flush  in  1  invalidates all lines; sampled only in IDLE.
- cpuRData  out  dataWidth  read data; valid while cpuReady=1.
- cpuReady  out  1  one-cycle completion pulse, registered.
- memReq  out  1  memory request; held until memAck.
- memWe  out  1  memory write enable.
- memAddr  out  addrSize  memory word address.
- memWData  out  dataWidth  memory write data.
- memRData  in  dataWidth  memory read data; valid in the memAck cycle.
- memAck  in  1  memory accepts or completes the current word in this cycle.
- hitCount  out  cntWidth  saturating count of hits.
- missCount  out  cntWidth  saturating count of misses.

## Operation
- State is held in a valid bit, a tag and 2^offset data words per line.

States:
- IDLE
  - flush=1: clears all valid bits and stays in IDLE. flush has priority over cpuReq, and the request is dropped.
  - cpuReq=1: latches addr, we and wdata, then goes to COMPARE.
  - cpuReq is ignored in every other state.
- COMPARE
  - hit = valid[idx] && storedTag[idx]==reqTag.
  - Read hit: cpuRData <= word, cpuReady pulse, hitCount+1, then IDLE.
  - Read miss: missCount+1, word counter cnt=0, then REFILL.
  - Write hit: updates the cached word, hitCount+1, then WRITE.
  - Write miss: missCount+1, then WRITE. No allocate; cache contents are unchanged.
- REFILL
  - memReq=1, memWe=0, memAddr={reqTag, reqIdx, cnt}.
  - On memAck, memRData is stored into data[reqIdx][cnt].
  - If cnt==reqOff, cpuRData <= memRData.
  - If cnt is not the last word, cnt+1.
  - On the last word's ack: valid[reqIdx]=1, tag written, cpuReady pulse, then IDLE.
  - The valid bit stays 0 during the refill. The old line is evicted unconditionally; there is no write-back.
- WRITE
  - memReq=1, memWe=1, memAddr=latched addr, memWData=latched data.
  - On memAck: cpuReady pulse, then IDLE.

Counters:
- hitCount and missCount saturate at all-ones and never wrap.

Reset (asynchronous):
- State goes to IDLE and all valid bits clear.
- cpuReady, memReq, memWe, memAddr, memWData, cpuRData, hitCount and missCount are all 0.
- Data and tag arrays are not reset.
- Reset during REFILL or WRITE aborts the transaction with no cpuReady; memReq drops immediately.

## Timing
- Read hit: cpuReq sampled at edge 0, COMPARE in cycle 1, cpuReady high in cycle 2. Back-to-back hits complete one every 2 cycles, because a new cpuReq is accepted in the cycle where cpuReady is high.
- Read miss: cpuReady is high in the cycle after the final (2^offset-th) memAck. The minimum is 2+2^offset cycles when memAck=1 continuously.
- Write: cpuReady is high in the cycle after memAck. The minimum is 3 cycles.
- memReq, memWe and memAddr are stable from assertion until the acking cycle. memAddr advances on the edge after each refill ack, so consecutive words may be acked on consecutive cycles.
- Counter updates are visible in the cycle after COMPARE.

## Test plan
All scenarios use the default parameters.
- Cold read of 0x105 (tag 1, idx 1, off 1) after reset, memory returning 0xA0+word for words 0x104..0x107:
  - four reads at 0x104..0x107;
  - cpuRData=0xA1;
  - missCount=1.
- Repeat the read of 0x105, with memAck held at 1 throughout: cpuReady exactly 2 cycles after the request, no memReq, cpuRData=0xA1, hitCount=1.
- Write 0xDEAD to 0x106, then read 0x106:
  - one memory write at 0x106 with 0xDEAD;
  - the read hits and returns 0xDEAD.
- Write to 0x305 (miss), then read 0x305:
  - a single memory write;
  - the following read misses and refills 0x304..0x307.
- Conflict: read 0x205 (tag 2, idx 1), then read 0x105:
  - both miss;
  - missCount increments by 2.
- Reset mid-operation and statistics:
  - Assert rst during the second refill word: memReq=0 immediately, no cpuReady; a re-read of the same address misses.
  - With cntWidth=2, four misses leave missCount=3.
  - flush asserted together with cpuReq: no request is serviced, and the next read of 0x105 misses.

Source files
------------

// File: rtl/direct_mapped_cache.sv
// Direct-mapped write-through cache: read hit answers in 2 cycles, misses refill 2^offset words.
// Memory side holds memReq until memAck; the CPU side takes one request at a time and is ready only in IDLE.
module direct_mapped_cache #(
  parameter int addrSize  = 30,
  parameter int offset    = 2,
  parameter int index     = 6,
  parameter int dataWidth = 32,
  parameter int cntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpuReq,
  input  logic                 cpuWe,
  input  logic [addrSize-1:0]  cpuAddr,
  input  logic [dataWidth-1:0] cpuWData,
  input  logic                 flush,
  output logic [dataWidth-1:0] cpuRData,
  output logic                 cpuReady,
  output logic                 memReq,
  output logic                 memWe,
  output logic [addrSize-1:0]  memAddr,
  output logic [dataWidth-1:0] memWData,
  input  logic [dataWidth-1:0] memRData,
  input  logic                 memAck,
  output logic [cntWidth-1:0]  hitCount,
  output logic [cntWidth-1:0]  missCount
);

  localparam int tagW   = addrSize - offset - index;
  localparam int nLines = 1 << index;
  localparam int nWords = 1 << offset;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_REFILL,
    S_WRITE
  } state_t;

  state_t               r_state;
  logic [nLines-1:0]    r_valid;
  logic [tagW-1:0]      r_tagMem  [nLines];
  logic [dataWidth-1:0] r_dataMem [nLines*nWords];
  logic                 r_we;
  logic [addrSize-1:0]  r_addr;
  logic [dataWidth-1:0] r_wdata;
  logic [offset-1:0]    r_cnt;

  logic [tagW-1:0]      w_reqTag;
  logic [index-1:0]     w_reqIdx;
  logic [offset-1:0]    w_reqOff;
  logic                 w_hit;
  logic                 w_lastWord;
  logic [offset-1:0]    w_cntNext;
  logic [dataWidth-1:0] w_hitWord;

  assign w_reqTag   = r_addr[addrSize-1 -: tagW];
  assign w_reqIdx   = r_addr[offset +: index];
  assign w_reqOff   = r_addr[offset-1:0];
  assign w_hit      = r_valid[w_reqIdx] && (r_tagMem[w_reqIdx] == w_reqTag);
  assign w_lastWord = (r_cnt == {offset{1'b1}});
  assign w_cntNext  = r_cnt + offset'(1);
  assign w_hitWord  = r_dataMem[{w_reqIdx, w_reqOff}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      cpuReady  <= 1'b0;
      cpuRData  <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      cpuReady <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (cpuReq) begin
            r_we    <= cpuWe;
            r_addr  <= cpuAddr;
            r_wdata <= cpuWData;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (hitCount != {cntWidth{1'b1}}) hitCount <= hitCount + cntWidth'(1);
          end else begin
            if (missCount != {cntWidth{1'b1}}) missCount <= missCount + cntWidth'(1);
          end
          if (!r_we && w_hit) begin
            cpuRData <= w_hitWord;
            cpuReady <= 1'b1;
            r_state  <= S_IDLE;
          end else if (!r_we) begin
            // The line is overwritten word by word, so it must read as invalid until the last ack.
            r_valid[w_reqIdx] <= 1'b0;
            r_cnt   <= '0;
            memReq  <= 1'b1;
            memWe   <= 1'b0;
            memAddr <= {w_reqTag, w_reqIdx, {offset{1'b0}}};
            r_state <= S_REFILL;
          end else begin
            memReq   <= 1'b1;
            memWe    <= 1'b1;
            memAddr  <= r_addr;
            memWData <= r_wdata;
            r_state  <= S_WRITE;
          end
        end
        S_REFILL: begin
          if (memAck) begin
            if (r_cnt == w_reqOff) cpuRData <= memRData;
            if (w_lastWord) begin
              r_valid[w_reqIdx] <= 1'b1;
              memReq   <= 1'b0;
              cpuReady <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_cnt   <= w_cntNext;
              memAddr <= {w_reqTag, w_reqIdx, w_cntNext};
            end
          end
        end
        S_WRITE: begin
          if (memAck) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            cpuReady <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide what is trusted.
  always_ff @(posedge clk) begin
    if (r_state == S_COMPARE && r_we && w_hit) begin
      r_dataMem[{w_reqIdx, w_reqOff}] <= r_wdata;
    end
    if (r_state == S_REFILL && memAck) begin
      r_dataMem[{w_reqIdx, r_cnt}] <= memRData;
      if (w_lastWord) r_tagMem[w_reqIdx] <= w_reqTag;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Randomised bench for direct_mapped_cache against a line/word level cache model and a memory model.
// A second instance with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_direct_mapped_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuReq, cpuWe, flush, memAck;
  logic [29:0] cpuAddr;
  logic [31:0] cpuWData, memRData;
  logic [31:0] cpuRData, memWData;
  logic        cpuReady, memReq, memWe;
  logic [29:0] memAddr;
  logic [15:0] hitCount, missCount;
  logic [31:0] s_cpuRData, s_memWData;
  logic        s_cpuReady, s_memReq, s_memWe;
  logic [29:0] s_memAddr;
  logic [1:0]  s_hitCount, s_missCount;

  always #5 clk = ~clk;

  direct_mapped_cache dut (
    .clk(clk), .rst(rst), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .cpuWData(cpuWData), .flush(flush), .cpuRData(cpuRData), .cpuReady(cpuReady),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .hitCount(hitCount), .missCount(missCount)
  );

  direct_mapped_cache #(.cntWidth(2)) dut_sat (
    .clk(clk), .rst(rst), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .cpuWData(cpuWData), .flush(flush), .cpuRData(s_cpuRData), .cpuReady(s_cpuReady),
    .memReq(s_memReq), .memWe(s_memWe), .memAddr(s_memAddr), .memWData(s_memWData),
    .memRData(memRData), .memAck(memAck), .hitCount(s_hitCount), .missCount(s_missCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
  } memop_t;

  // Reference model: per-line valid/tag/words plus the memory contents the CPU should see.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_line  [64][4];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] env_mem [logic [29:0]];
  int          m_hits, m_misses;

  memop_t op_log[$];
  bit     req_seen;
  int     ack_policy;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h3C5A_0F96;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] env_rd(input logic [29:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Memory responder: acks are driven on the falling edge and sampled by the DUT on the next rising edge.
  always @(negedge clk) begin : responder
    bit a;
    case (ack_policy)
      0:       a = 1'b1;
      1:       a = ($urandom_range(0, 1) == 1);
      2:       a = 1'b0;
      default: a = memReq && (memAddr[1:0] == 2'd0);
    endcase
    memAck   = a;
    memRData = env_rd(memAddr);
    if (memReq) req_seen = 1'b1;
    if (memReq && a) begin
      op_log.push_back('{memWe, memAddr, memWData});
      if (memWe) env_mem[memAddr] = memWData;
    end
  end

  task automatic do_op(input bit we, input logic [29:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
    logic [21:0] tg;
    logic [5:0]  idx;
    logic [1:0]  off;
    bit          hit;
    logic [31:0] exp_rd;
    memop_t      exp_ops[$];
    tg  = addr[29:8];
    idx = addr[7:2];
    off = addr[1:0];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_rd = '0;
    if (!we) begin
      if (!hit) begin
        for (int k = 0; k < 4; k++) begin
          exp_ops.push_back('{1'b0, {tg, idx, 2'(k)}, 32'h0});
          m_line[idx][k] = ref_rd({tg, idx, 2'(k)});
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
      exp_rd = m_line[idx][off];
    end else begin
      exp_ops.push_back('{1'b1, addr, wd});
      if (hit) m_line[idx][off] = wd;
      ref_mem[addr] = wd;
    end
    if (hit) m_hits++; else m_misses++;

    @(negedge clk);
    op_log.delete();
    req_seen = 1'b0;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuWData = wd;
    @(posedge clk);
    #1;
    cpuReq = 1'b0;
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (cpuReady) begin
        lat = n + 1;
        break;
      end
    end
    rd = cpuRData;
    if (lat == 0) begin
      check_eq("op_timeout", 0, 1);
      return;
    end
    if (!we) begin
      check_eq("rdata", cpuRData, exp_rd);
      check_eq("sat_rdata", s_cpuRData, exp_rd);
    end
    check_eq("sat_ready", s_cpuReady, 1);
    if (hit && !we) begin
      check_eq("hit_latency", lat, 2);
      check_eq("hit_no_memreq", req_seen, 0);
    end else if (ack_policy == 0) begin
      check_eq("full_ack_latency", lat, we ? 3 : 6);
    end
    check_eq("memop_count", op_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++) begin
      check_eq("memop_we", op_log[i].we, exp_ops[i].we);
      check_eq("memop_addr", op_log[i].addr, exp_ops[i].addr);
      if (exp_ops[i].we) check_eq("memop_wdata", op_log[i].data, exp_ops[i].data);
    end
    check_eq("hit_count", hitCount, sat(m_hits, 65535));
    check_eq("miss_count", missCount, sat(m_misses, 65535));
    check_eq("sat_hit_count", s_hitCount, sat(m_hits, 3));
    check_eq("sat_miss_count", s_missCount, sat(m_misses, 3));
  endtask

  task automatic do_flush_with_req(input logic [29:0] addr);
    bit busy;
    @(negedge clk);
    flush   = 1'b1;
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = addr;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    cpuReq = 1'b0;
    busy   = cpuReady | memReq;
    repeat (3) begin
      @(posedge clk);
      #1;
      busy = busy | cpuReady | memReq;
    end
    check_eq("flush_drops_req", busy, 0);
    model_clear();
  endtask

  task automatic do_reset_mid_refill(input logic [29:0] addr);
    bit found;
    bit rdy;
    ack_policy = 3;
    @(negedge clk);
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = addr;
    @(posedge clk);
    #1;
    cpuReq = 1'b0;
    found  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (memReq && memAddr == {addr[29:2], 2'd1}) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_second_word", found, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_memreq_drop", memReq, 0);
    check_eq("rst_no_ready", cpuReady, 0);
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      rdy = rdy | cpuReady;
    end
    check_eq("abort_no_ready", rdy, 0);
    model_clear();
    m_hits   = 0;
    m_misses = 0;
    check_eq("rst_hit_count", hitCount, 0);
    check_eq("rst_miss_count", missCount, 0);
    ack_policy = 0;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [15:0] m0;

  initial begin
    rst      = 1'b1;
    cpuReq   = 1'b0;
    cpuWe    = 1'b0;
    cpuAddr  = '0;
    cpuWData = '0;
    flush    = 1'b0;
    memAck   = 1'b0;
    memRData = '0;
    ack_policy = 0;
    m_hits   = 0;
    m_misses = 0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      ref_mem[30'h104 + 30'(k)] = 32'hA0 + 32'(k);
      env_mem[30'h104 + 30'(k)] = 32'hA0 + 32'(k);
    end
    repeat (2) @(negedge clk);
    check_eq("rst_cpuReady", cpuReady, 0);
    check_eq("rst_cpuRData", cpuRData, 0);
    check_eq("rst_memReq", memReq, 0);
    check_eq("rst_memWe", memWe, 0);
    check_eq("rst_memAddr", memAddr, 0);
    check_eq("rst_memWData", memWData, 0);
    check_eq("rst_hitCount", hitCount, 0);
    check_eq("rst_missCount", missCount, 0);
    rst = 1'b0;

    do_op(1'b0, 30'h105, 32'h0, rd, lat);
    check_eq("cold_rdata", rd, 32'hA1);
    check_eq("cold_misses", missCount, 1);
    check_eq("cold_latency", lat, 6);

    do_op(1'b0, 30'h105, 32'h0, rd, lat);
    check_eq("rehit_rdata", rd, 32'hA1);
    check_eq("rehit_latency", lat, 2);
    check_eq("rehit_hits", hitCount, 1);

    do_op(1'b1, 30'h106, 32'hDEAD, rd, lat);
    check_eq("write_latency", lat, 3);
    do_op(1'b0, 30'h106, 32'h0, rd, lat);
    check_eq("write_then_read", rd, 32'hDEAD);

    do_op(1'b1, 30'h305, 32'h1234_5678, rd, lat);
    do_op(1'b0, 30'h305, 32'h0, rd, lat);
    check_eq("write_miss_readback", rd, 32'h1234_5678);

    m0 = missCount;
    do_op(1'b0, 30'h205, 32'h0, rd, lat);
    do_op(1'b0, 30'h105, 32'h0, rd, lat);
    check_eq("conflict_misses", missCount, m0 + 16'd2);
    check_eq("sat_miss_is_3", s_missCount, 3);

    do_flush_with_req(30'h105);
    m0 = missCount;
    do_op(1'b0, 30'h105, 32'h0, rd, lat);
    check_eq("flush_then_miss", missCount, m0 + 16'd1);

    do_reset_mid_refill(30'h0A9);
    do_op(1'b0, 30'h0A9, 32'h0, rd, lat);
    check_eq("reread_after_rst_misses", missCount, 1);

    for (int i = 0; i < 300; i++) begin
      logic [29:0] a;
      a = {20'h0, 2'(i % 4 == 3 ? 2 : $urandom_range(0, 3)), 4'h0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      ack_policy = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) begin
        do_flush_with_req(a);
      end else begin
        do_op($urandom_range(0, 9) < 3, a, $urandom, rd, lat);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
